// File: rtl/div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_pkg : shared FSM state type and width helper for seq_restoring_div
// Revision: 1.0
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_mux_row.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sub_mux_row : ripple subtract-with-borrow row with restore select
// Revision: 1.0
// ---------------------------------------------------------------------------
module sub_mux_row #(
  parameter int N = 9
) (
  input  logic [N-1:0] p_in,
  input  logic [N-1:0] d_in,
  output logic [N-1:0] p_next,
  output logic         borrow_out
);

  logic [N:0]   borrow;
  logic [N-1:0] diff;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff[i]     = p_in[i] ^ d_in[i] ^ borrow[i];
    assign borrow[i+1] = (~p_in[i] & d_in[i]) | (~(p_in[i] ^ d_in[i]) & borrow[i]);
    // A borrow out of the top cell means the trial subtract went negative: restore.
    assign p_next[i]   = borrow[N] ? p_in[i] : diff[i];
  end

  assign borrow_out = borrow[N];

endmodule
`default_nettype wire

// File: rtl/seq_restoring_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_restoring_div : one-bit-per-cycle unsigned restoring divider
// Optional macro DIV_ZERO_DETECT_EN: short-circuit divide-by-zero, drive dbz.
// Revision: 1.0
// ---------------------------------------------------------------------------
module seq_restoring_div
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CW = clog2(WIDTH);

  state_t           state;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [2*WIDTH:0] pq_shift;
  logic [WIDTH:0]   p_sel;
  logic             borrow;
  logic [WIDTH-1:0] q_next;

  assign pq_shift = {p, q} << 1;
  assign q_next   = pq_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~borrow};
  assign busy     = (state == RUN);

  sub_mux_row #(
    .N(WIDTH + 1)
  ) u_row (
    .p_in      (pq_shift[2*WIDTH:WIDTH]),
    .d_in      ({1'b0, d}),
    .p_next    (p_sel),
    .borrow_out(borrow)
  );

`ifdef DIV_ZERO_DETECT_EN
  logic zero_pend;
  logic dbz_r;
  assign dbz = dbz_r;
`else
  assign dbz = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      zero_pend <= 1'b0;
      dbz_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
`ifdef DIV_ZERO_DETECT_EN
          // Zero divisor: results publish one edge after the accept, q still holds the dividend.
          if (zero_pend) begin
            zero_pend <= 1'b0;
            done      <= 1'b1;
            quotient  <= '1;
            remainder <= q;
            dbz_r     <= 1'b1;
          end else
`endif
          if (start) begin
            q   <= dividend;
            d   <= divisor;
            p   <= '0;
            cnt <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_DETECT_EN
            if (divisor == '0) begin
              state     <= DONE;
              zero_pend <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p   <= p_sel;
          q   <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= p_sel[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
            dbz_r     <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
